// File: rtl/sdram_cmd_sequencer.sv
// sdram_cmd_sequencer
//
// Purpose: SDRAM command sequencer. Runs the power-up sequence (NOP, precharge
// all, mode-register set), then serves single-burst read/write requests and
// auto-refresh requests. Every gap between commands is timed by the shared
// delay_generator: the sequencer pulses one load_* strobe when it enters a
// wait state, then waits for countout to reach zero.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   host request handshake (ready is combinational)
//   req_write, req_addr   burst direction and {bank, row, col} address
//   refresh_req/ack       level refresh request, ack pulses with REF command
//   mode_cfg              mode word, captured once after reset
//   program_data          captured mode word, fed to delay_generator
//   load_twait/tpre/tcas/tburst, countout   delay_generator control/status
//   cs_n/ras_n/cas_n/we_n, ba, addr         SDRAM command/address pins
//   data_phase, data_write                  burst data cycle and direction
module sdram_cmd_sequencer #(
  parameter int ROW_W = 12,
  parameter int COL_W = 8,
  parameter int BA_W  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic                          req_write,
  input  logic [BA_W+ROW_W+COL_W-1:0]   req_addr,
  output logic                          req_ready,
  input  logic                          refresh_req,
  output logic                          refresh_ack,
  input  logic [9:0]                    mode_cfg,
  output logic [9:0]                    program_data,
  output logic                          load_twait,
  output logic                          load_tpre,
  output logic                          load_tcas,
  output logic                          load_tburst,
  input  logic [9:0]                    countout,
  output logic                          cs_n,
  output logic                          ras_n,
  output logic                          cas_n,
  output logic                          we_n,
  output logic [BA_W-1:0]               ba,
  output logic [ROW_W-1:0]              addr,
  output logic                          data_phase,
  output logic                          data_write
);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  // addr[10] selects "all banks" on PRE and auto-precharge on READ/WRITE
  localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(1) << 10;

  // S_BOOT is the single cycle after reset where outputs still show reset
  // values; the init sequence starts from the following cycle.
  typedef enum logic [3:0] {
    S_BOOT,
    S_INIT_NOP,
    S_INIT_PRE,
    S_INIT_MRS,
    S_IDLE,
    S_REF,
    S_ACT,
    S_RW,
    S_DATA,
    S_PRE
  } state_t;

  state_t            state_q;
  logic              first_q;      // high in the entry cycle of a wait state
  logic [3:0]        cmd_q;
  logic [BA_W-1:0]   ba_q;
  logic [ROW_W-1:0]  addr_q;
  logic              load_twait_q;
  logic              load_tpre_q;
  logic              load_tcas_q;
  logic              load_tburst_q;
  logic              refresh_ack_q;
  logic              data_phase_q;
  logic              data_write_q;
  logic [9:0]        program_data_q;
  logic [BA_W-1:0]   bank_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic              write_q;

  logic [BA_W-1:0]   req_bank;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic              wait_done;
  logic              more_data;

  assign req_bank = req_addr[BA_W+ROW_W+COL_W-1 -: BA_W];
  assign req_row  = req_addr[ROW_W+COL_W-1 -: ROW_W];
  assign req_col  = req_addr[COL_W-1:0];

  // countout still holds the previous delay in the entry cycle, so it is
  // only trusted from the second cycle of a wait state onwards.
  assign wait_done = ~first_q & (countout == '0);

  // data_phase is registered, so it is predicted one cycle ahead: the word
  // count seen next cycle will be countout - 1.
  assign more_data = countout > 10'd1;

  assign req_ready = (state_q == S_IDLE) & ~refresh_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_BOOT;
      first_q        <= 1'b0;
      cmd_q          <= CMD_NOP;
      ba_q           <= '0;
      addr_q         <= '0;
      load_twait_q   <= 1'b0;
      load_tpre_q    <= 1'b0;
      load_tcas_q    <= 1'b0;
      load_tburst_q  <= 1'b0;
      refresh_ack_q  <= 1'b0;
      data_phase_q   <= 1'b0;
      data_write_q   <= 1'b0;
      program_data_q <= '0;
      bank_q         <= '0;
      row_q          <= '0;
      col_q          <= '0;
      write_q        <= 1'b0;
    end else begin
      // Single-cycle defaults: commands and strobes last exactly one cycle.
      first_q       <= 1'b0;
      cmd_q         <= CMD_NOP;
      ba_q          <= '0;
      addr_q        <= '0;
      load_twait_q  <= 1'b0;
      load_tpre_q   <= 1'b0;
      load_tcas_q   <= 1'b0;
      load_tburst_q <= 1'b0;
      refresh_ack_q <= 1'b0;
      data_phase_q  <= 1'b0;
      data_write_q  <= 1'b0;

      unique case (state_q)
        S_BOOT: begin
          state_q        <= S_INIT_NOP;
          first_q        <= 1'b1;
          load_twait_q   <= 1'b1;
          program_data_q <= mode_cfg;
        end

        S_INIT_NOP: begin
          if (wait_done) begin
            state_q     <= S_INIT_PRE;
            first_q     <= 1'b1;
            cmd_q       <= CMD_PRE;
            addr_q      <= ADDR_A10;
            load_tpre_q <= 1'b1;
          end
        end

        S_INIT_PRE: begin
          if (wait_done) begin
            state_q      <= S_INIT_MRS;
            first_q      <= 1'b1;
            cmd_q        <= CMD_MRS;
            addr_q       <= ROW_W'(program_data_q);
            load_twait_q <= 1'b1;
          end
        end

        S_INIT_MRS: begin
          if (wait_done) state_q <= S_IDLE;
        end

        S_IDLE: begin
          // Refresh wins a tie; the host request simply stays pending.
          if (refresh_req) begin
            state_q       <= S_REF;
            first_q       <= 1'b1;
            cmd_q         <= CMD_REF;
            load_twait_q  <= 1'b1;
            refresh_ack_q <= 1'b1;
          end else if (req_valid) begin
            state_q      <= S_ACT;
            first_q      <= 1'b1;
            cmd_q        <= CMD_ACT;
            ba_q         <= req_bank;
            addr_q       <= req_row;
            load_twait_q <= 1'b1;
            bank_q       <= req_bank;
            row_q        <= req_row;
            col_q        <= req_col;
            write_q      <= req_write;
          end
        end

        S_REF: begin
          if (wait_done) state_q <= S_IDLE;
        end

        S_ACT: begin
          if (wait_done) begin
            state_q     <= S_RW;
            first_q     <= 1'b1;
            cmd_q       <= write_q ? CMD_WRITE : CMD_READ;
            ba_q        <= bank_q;
            addr_q      <= ROW_W'(col_q);  // addr[10] = 0: no auto-precharge
            load_tcas_q <= 1'b1;
          end
        end

        S_RW: begin
          if (wait_done) begin
            state_q       <= S_DATA;
            first_q       <= 1'b1;
            load_tburst_q <= 1'b1;
          end
        end

        S_DATA: begin
          if (first_q) begin
            // Burst length is at least 1, so the first word always follows.
            data_phase_q <= 1'b1;
            data_write_q <= write_q;
          end else if (countout == '0) begin
            state_q     <= S_PRE;
            first_q     <= 1'b1;
            cmd_q       <= CMD_PRE;
            ba_q        <= bank_q;
            load_tpre_q <= 1'b1;
          end else begin
            data_phase_q <= more_data;
            data_write_q <= more_data & write_q;
          end
        end

        S_PRE: begin
          if (wait_done) state_q <= S_IDLE;
        end

        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
  assign ba           = ba_q;
  assign addr         = addr_q;
  assign load_twait   = load_twait_q;
  assign load_tpre    = load_tpre_q;
  assign load_tcas    = load_tcas_q;
  assign load_tburst  = load_tburst_q;
  assign refresh_ack  = refresh_ack_q;
  assign data_phase   = data_phase_q;
  assign data_write   = data_write_q;
  assign program_data = program_data_q;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// tb_sdram_cmd_sequencer
//
// Bench for sdram_cmd_sequencer. Contains a behavioural delay_generator,
// a scoreboard of expected command/load events and data bursts (pushed
// when stimulus is driven, popped when the DUT shows them), and directed
// scenarios: init, read, refresh/request tie, reset mid-burst, long write.
module tb_sdram_cmd_sequencer;

  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_ACT   = 4'b0011;
  localparam logic [3:0] C_READ  = 4'b0101;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_PRE   = 4'b0010;
  localparam logic [3:0] C_REF   = 4'b0001;
  localparam logic [3:0] C_MRS   = 4'b0000;

  // load bit order {twait, tpre, tcas, tburst}
  localparam logic [3:0] L_TWAIT  = 4'b1000;
  localparam logic [3:0] L_TPRE   = 4'b0100;
  localparam logic [3:0] L_TCAS   = 4'b0010;
  localparam logic [3:0] L_TBURST = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_ready;
  logic [21:0] req_addr;
  logic        refresh_req, refresh_ack;
  logic [9:0]  mode_cfg, program_data, countout;
  logic        load_twait, load_tpre, load_tcas, load_tburst;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [11:0] addr;
  logic        data_phase, data_write;

  sdram_cmd_sequencer #(.ROW_W(12), .COL_W(8), .BA_W(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_ready(req_ready),
    .refresh_req(refresh_req), .refresh_ack(refresh_ack),
    .mode_cfg(mode_cfg), .program_data(program_data),
    .load_twait(load_twait), .load_tpre(load_tpre),
    .load_tcas(load_tcas), .load_tburst(load_tburst),
    .countout(countout),
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr),
    .data_phase(data_phase), .data_write(data_write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural delay_generator: load in cycle t with value N gives
  // countout = N in t+1, counting down to 0 in t+1+N.
  logic [9:0] cnt_q = '0;
  assign countout = cnt_q;
  always @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (load_twait | load_tpre | load_tcas) cnt_q <= 10'd3;
    else if (load_tburst)
      cnt_q <= (program_data[2:0] == 3'd7) ? 10'd1023 : (10'd1 << program_data[2:0]);
    else if (cnt_q != 0) cnt_q <= cnt_q - 10'd1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic [3:0] ld;
    bit         chk_ba;
    logic [1:0] ba;
    bit         chk_addr;
    logic [11:0] addr;
  } ev_t;

  typedef struct {
    int start;
    int len;
    bit wr;
  } burst_t;

  ev_t    exp_q[$];
  burst_t burst_q[$];

  function automatic ev_t mk_ev(int c, logic [3:0] cmd, logic [3:0] ld,
                                bit cb, logic [1:0] b, bit ca, logic [11:0] a);
    ev_t e;
    e.cyc = c; e.cmd = cmd; e.ld = ld;
    e.chk_ba = cb; e.ba = b; e.chk_addr = ca; e.addr = a;
    return e;
  endfunction

  // Monitor: one line per observed command/load event and per burst.
  int         run = 0;
  int         run_start = 0;
  logic       run_dw = 1'b0;
  bit         run_mixed = 1'b0;
  always @(negedge clk) begin
    logic [3:0] cmd_now, ld_now;
    ev_t    e;
    burst_t b;
    if (reset) begin
      run = 0;
    end else begin
      cmd_now = {cs_n, ras_n, cas_n, we_n};
      ld_now  = {load_twait, load_tpre, load_tcas, load_tburst};
      if (cmd_now != C_NOP || ld_now != 4'b0) begin
        $display("cyc %0d: cmd=%b load=%b ba=%0d addr=0x%03h", cyc, cmd_now, ld_now, ba, addr);
        if (exp_q.size() == 0) begin
          check_eq("event_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq("ev_cycle", cyc, e.cyc);
          check_eq("ev_cmd", cmd_now, e.cmd);
          check_eq("ev_load", ld_now, e.ld);
          if (e.chk_ba) check_eq("ev_ba", ba, e.ba);
          if (e.chk_addr) check_eq("ev_addr", addr, e.addr);
        end
      end
      if (cmd_now == C_REF || refresh_ack)
        check_eq("refresh_ack", refresh_ack, cmd_now == C_REF);
      if (data_phase) begin
        if (run == 0) begin
          run_start = cyc; run_dw = data_write; run_mixed = 1'b0;
        end else if (data_write != run_dw) begin
          run_mixed = 1'b1;
        end
        run++;
      end else if (run != 0) begin
        $display("cyc %0d: burst start=%0d len=%0d write=%0d", cyc, run_start, run, run_dw);
        if (burst_q.size() == 0) begin
          check_eq("burst_expected", burst_q.size(), 1);
        end else begin
          b = burst_q.pop_front();
          check_eq("burst_start", run_start, b.start);
          check_eq("burst_len", run, b.len);
          check_eq("burst_dir", run_mixed ? 2 : run_dw, b.wr);
        end
        run = 0;
      end
    end
  end

  task automatic check_rst_outputs(input string where);
    $display("cyc %0d: reset-value check (%s)", cyc, where);
    check_eq({where, "_cmd"}, {cs_n, ras_n, cas_n, we_n}, C_NOP);
    check_eq({where, "_loads"}, {load_twait, load_tpre, load_tcas, load_tburst}, 0);
    check_eq({where, "_baaddr"}, {ba, addr}, 0);
    check_eq({where, "_data"}, {data_phase, data_write, refresh_ack}, 0);
    check_eq({where, "_pd"}, program_data, 0);
    check_eq({where, "_ready"}, req_ready, 0);
  endtask

  task automatic wait_idle(input string tag, input int exp_cyc);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    $display("cyc %0d: idle (%s)", cyc, tag);
    check_eq(tag, cyc, exp_cyc);
  endtask

  // r0 is the first cycle with reset low (outputs still at reset values).
  task automatic run_init(input logic [9:0] mode, input int r0);
    exp_q.push_back(mk_ev(r0 + 1, C_NOP, L_TWAIT, 0, 2'd0, 0, 12'h0));
    exp_q.push_back(mk_ev(r0 + 6, C_PRE, L_TPRE, 0, 2'd0, 1, 12'h400));
    exp_q.push_back(mk_ev(r0 + 11, C_MRS, L_TWAIT, 1, 2'd0, 1, {2'b00, mode}));
    wait_idle("init_ready", r0 + 16);
    check_eq("init_pd", program_data, mode);
  endtask

  // Waits for the handshake on an already-driven request, then pushes the
  // expected command sequence relative to the accept cycle.
  task automatic accept_wait(input bit wr, input logic [1:0] bank, input logic [11:0] row,
                             input logic [7:0] col, input int blen, output int a);
    a = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin a = cyc; break; end
    end
    check_eq("accept", req_ready, 1);
    $display("cyc %0d: accept wr=%0d bank=%0d row=0x%03h col=0x%02h", a, wr, bank, row, col);
    exp_q.push_back(mk_ev(a + 1, C_ACT, L_TWAIT, 1, bank, 1, row));
    exp_q.push_back(mk_ev(a + 6, wr ? C_WRITE : C_READ, L_TCAS, 1, bank, 1, {4'h0, col}));
    exp_q.push_back(mk_ev(a + 11, C_NOP, L_TBURST, 0, 2'd0, 0, 12'h0));
    burst_q.push_back('{start: a + 12, len: blen, wr: wr});
    exp_q.push_back(mk_ev(a + 13 + blen, C_PRE, L_TPRE, 1, bank, 1, 12'h000));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_req(input bit wr, input logic [1:0] bank, input logic [11:0] row,
                        input logic [7:0] col, input int blen, output int a);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = {bank, row, col};
    accept_wait(wr, bank, row, col, blen, a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r, r0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    refresh_req = 1'b0; mode_cfg = 10'h012;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    r0 = cyc;
    @(negedge clk);
    check_rst_outputs("rst1");
    run_init(10'h012, r0);

    // mode_cfg changes after init must not affect program_data or bursts
    mode_cfg = 10'h3FF;
    @(posedge clk); #1;
    check_eq("pd_hold", program_data, 10'h012);

    do_req(1'b0, 2'd1, 12'h0A5, 8'h3C, 4, a);
    wait_idle("read_idle", a + 22);
    check_eq("pd_hold2", program_data, 10'h012);

    // refresh and request together: REF first, request waits
    @(posedge clk); #1;
    r = cyc;
    refresh_req = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = {2'd2, 12'h123, 8'h55};
    exp_q.push_back(mk_ev(r + 1, C_REF, L_TWAIT, 0, 2'd0, 0, 12'h0));
    @(negedge clk);
    check_eq("ready_during_refresh", req_ready, 0);
    for (int k = 0; k < 20; k++) begin
      if (refresh_ack) break;
      @(negedge clk);
    end
    check_eq("ack_cycle", cyc, r + 1);
    @(posedge clk);
    check_eq("ready_refresh_held", req_ready, 0);
    #1 refresh_req = 1'b0;
    accept_wait(1'b1, 2'd2, 12'h123, 8'h55, 4, a);
    check_eq("accept_after_ref", a, r + 6);
    wait_idle("wr_idle", a + 22);

    // reset during the third data_phase cycle
    do_req(1'b0, 2'd3, 12'h3C3, 8'hA5, 4, a);
    for (int k = 0; k < 100 && cyc < a + 14; k++) @(negedge clk);
    check_eq("dp_third", data_phase, 1);
    #1 reset = 1'b1;
    exp_q.delete();
    burst_q.delete();
    mode_cfg = 10'h017;
    @(negedge clk);
    check_rst_outputs("rst_mid");
    @(posedge clk);
    #1 reset = 1'b0;
    r0 = cyc;
    @(negedge clk);
    check_rst_outputs("rst2");
    run_init(10'h017, r0);

    // burst code 7: 1023-word write
    do_req(1'b1, 2'd0, 12'hFFF, 8'hFF, 1023, a);
    wait_idle("long_idle", a + 18 + 1023);

    repeat (5) @(negedge clk);
    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("burst_q_drained", burst_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
